// File: rtl/load_unit.sv
// Load unit: accepts one load, issues a word-aligned memory read, extends the
// selected byte/halfword/word and writes it back. Optional memory timeout under LOAD_UNIT_TIMEOUT_EN.
module load_unit
`ifdef LOAD_UNIT_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 16)
`endif
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_funct3,
  output logic        o_ready,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wr_enable,
  output logic [31:0] o_wr_data,
  output logic        o_misaligned,
  output logic        o_timeout,
  output logic [1:0]  o_dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Handshake: a request is taken on a rising edge where i_valid & o_ready;
  // o_ready is high only in IDLE, so inputs are never sampled mid-operation.

  logic [1:0]  state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        accept;
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_bad;
  logic        ack_in_req;
  logic        timeout_hit;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_result;

  assign accept     = (state_q == ST_IDLE) && i_valid;
  assign ack_in_req = (state_q == ST_REQ) && i_mem_ack;

  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    case (i_funct3)
      F3_LB, F3_LBU: begin
        req_misaligned = 1'b0;
      end
      F3_LH, F3_LHU: begin
        req_misaligned = i_addr[0];
      end
      F3_LW: begin
        req_misaligned = |i_addr[1:0];
      end
      default: begin
        req_illegal = 1'b1;
      end
    endcase
  end

  assign req_bad = req_illegal || req_misaligned;

  // Lane selection uses the captured byte offset, never the live input.
  always_comb begin
    byte_sel    = i_mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel    = i_mem_rdata[{lane_q[1], 4'b0000} +: 16];
    load_result = i_mem_rdata;
    case (funct3_q)
      F3_LB:   load_result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_result = {24'd0, byte_sel};
      F3_LH:   load_result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_result = {16'd0, half_sel};
      default: load_result = i_mem_rdata;
    endcase
  end

`ifdef LOAD_UNIT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;

  // An ack arriving on the last allowed cycle wins over the abort.
  assign timeout_hit = (state_q == ST_REQ) && !i_mem_ack && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !req_bad) begin
      cnt_d = '0;
    end else if ((state_q == ST_REQ) && !i_mem_ack) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_hit;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          state_d = req_bad ? ST_ERR : ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_mem_ack) begin
          state_d = ST_WB;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_WB:  state_d = ST_IDLE;
      ST_ERR: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr_d = mem_addr_q;
    lane_d     = lane_q;
    funct3_d   = funct3_q;
    wr_data_d  = wr_data_q;
    if (accept) begin
      mem_addr_d = {i_addr[31:2], 2'b00};
      lane_d     = i_addr[1:0];
      funct3_d   = i_funct3;
    end
    if (ack_in_req) begin
      wr_data_d = load_result;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      lane_q     <= '0;
      funct3_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      lane_q     <= lane_d;
      funct3_q   <= funct3_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign o_ready      = (state_q == ST_IDLE);
  assign o_mem_req    = (state_q == ST_REQ);
  assign o_mem_addr   = mem_addr_q;
  assign o_wr_enable  = (state_q == ST_WB);
  assign o_wr_data    = wr_data_q;
  assign o_misaligned = (state_q == ST_ERR);
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: directed corner loads plus random loads, checked by a
// queue-based scoreboard against an arithmetic reference model.
module tb_load_unit;

  localparam int K_WR  = 0;
  localparam int K_ERR = 1;
  localparam int K_TO  = 2;
  localparam int TO_CYC = 16;
`ifdef LOAD_UNIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [31:0] addr;
    int          req_len;
  } txn_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_addr = '0;
  logic [2:0]  i_funct3 = '0;
  logic        o_ready;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_wr_enable;
  logic [31:0] o_wr_data;
  logic        o_misaligned;
  logic        o_timeout;
  logic [1:0]  o_dbg_state;

  txn_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          req_cnt = 0;
  logic [31:0] last_wr = '0;
  logic [1:0]  idle_code = '0;

  load_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_addr(i_addr),
    .i_funct3(i_funct3), .o_ready(o_ready), .o_mem_req(o_mem_req),
    .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_wr_enable(o_wr_enable), .o_wr_data(o_wr_data), .o_misaligned(o_misaligned),
    .o_timeout(o_timeout), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset block
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  function automatic bit is_bad(input logic [31:0] addr, input logic [2:0] f3);
    int unsigned a;
    a = addr;
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (a % 2) != 0;
      3'd2:       return (a % 4) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic [31:0] addr, input logic [2:0] f3,
                                        input logic [31:0] rd);
    longint v;
    longint unsigned w;
    int unsigned a;
    a = addr;
    w = rd;
    v = 0;
    case (f3)
      3'd0: begin v = longint'((w >> (8 * (a % 4))) % 256); if (v >= 128) v -= 256; end
      3'd4: v = longint'((w >> (8 * (a % 4))) % 256);
      3'd1: begin v = longint'((w >> (16 * ((a % 4) / 2))) % 65536); if (v >= 32768) v -= 65536; end
      3'd5: v = longint'((w >> (16 * ((a % 4) / 2))) % 65536);
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  // Monitor / scoreboard
  always @(negedge i_clk) begin
    if (i_rst) begin
      if (o_mem_req) begin
        req_cnt++;
        check("req_not_idle_state", {31'd0, o_dbg_state != idle_code}, 32'd1);
        if (exp_q.size() == 0) begin
          check("req_unexpected", 32'd1, 32'd0);
        end else begin
          check("mem_addr", o_mem_addr, exp_q[0].addr);
          check("req_on_bad", {31'd0, exp_q[0].kind == K_ERR}, 32'd0);
        end
      end
      if (o_wr_enable || o_misaligned || o_timeout) begin
        txn_t t;
        int kind;
        check("one_event", 32'(int'(o_wr_enable) + int'(o_misaligned) + int'(o_timeout)), 32'd1);
        kind = o_wr_enable ? K_WR : (o_misaligned ? K_ERR : K_TO);
        if (exp_q.size() == 0) begin
          check("event_unexpected", 32'(kind), 32'hFFFF_FFFF);
        end else begin
          t = exp_q.pop_front();
          check("event_kind", 32'(kind), 32'(t.kind));
          if (t.kind == K_WR) begin
            check("wr_data", o_wr_data, t.data);
            check("req_cycles", 32'(req_cnt), 32'(t.req_len));
            last_wr = t.data;
          end else if (t.kind == K_ERR) begin
            check("err_no_req", 32'(req_cnt), 32'd0);
            check("err_wr_data_held", o_wr_data, last_wr);
          end else begin
            check("to_req_cycles", 32'(req_cnt), 32'(t.req_len));
            check("to_ready", {31'd0, o_ready}, 32'd1);
            check("to_wr_data_held", o_wr_data, last_wr);
          end
        end
        req_cnt = 0;
      end
    end
  end

  // Driver tasks
  task automatic wait_ready();
    for (int i = 0; i < 40; i++) begin
      if (o_ready) break;
      @(posedge i_clk); #1;
    end
    check("ready_wait", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rd, input int delay);
    txn_t t;
    bit bad;
    bit to;
    wait_ready();
    bad = is_bad(addr, f3);
    to = !bad && TO_EN && (delay >= TO_CYC);
    t.addr = addr - (addr % 4);
    t.data = '0;
    t.req_len = 0;
    if (bad) t.kind = K_ERR;
    else if (to) begin t.kind = K_TO; t.req_len = TO_CYC; end
    else begin t.kind = K_WR; t.data = model(addr, f3, rd); t.req_len = delay + 1; end
    exp_q.push_back(t);
    i_valid = 1'b1; i_addr = addr; i_funct3 = f3;
    i_mem_ack = 1'($urandom_range(0, 1)); i_mem_rdata = $urandom;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_addr = $urandom; i_funct3 = 3'($urandom_range(0, 7));
    if (bad) begin
      i_mem_ack = 1'($urandom_range(0, 1));
      return;
    end
    for (int d = 0; d < (to ? TO_CYC : delay); d++) begin
      i_mem_ack = 1'b0;
      i_valid = 1'($urandom_range(0, 1));
      i_addr = $urandom; i_funct3 = 3'($urandom_range(0, 7));
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    if (to) begin
      i_mem_ack = 1'b0;
      return;
    end
    i_mem_ack = 1'b1; i_mem_rdata = rd;
    i_valid = 1'($urandom_range(0, 1));
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_mem_ack = 1'($urandom_range(0, 1)); i_mem_rdata = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    check({tag, "_mem_req"}, {31'd0, o_mem_req}, 32'd0);
    check({tag, "_mem_addr"}, o_mem_addr, 32'd0);
    check({tag, "_wr_en"}, {31'd0, o_wr_enable}, 32'd0);
    check({tag, "_wr_data"}, o_wr_data, 32'd0);
    check({tag, "_misaligned"}, {31'd0, o_misaligned}, 32'd0);
    check({tag, "_timeout"}, {31'd0, o_timeout}, 32'd0);
  endtask

  task automatic reset_mid_req();
    txn_t t;
    wait_ready();
    t.kind = K_WR; t.addr = 32'h40; t.data = '0; t.req_len = 0;
    exp_q.push_back(t);
    i_valid = 1'b1; i_addr = 32'h40; i_funct3 = 3'd2;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_mem_ack = 1'b0;
    repeat (2) begin @(posedge i_clk); #1; end
    i_rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    req_cnt = 0;
    last_wr = '0;
    i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678;
    repeat (2) @(posedge i_clk);
    #3;
    check_reset_outputs("mid_rst_hold");
    i_mem_ack = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
  endtask

  initial begin
    #2;
    check_reset_outputs("rst");
    idle_code = o_dbg_state;
    repeat (2) @(posedge i_clk);
    #3 i_rst = 1'b1;
    @(negedge i_clk);
    check_reset_outputs("post_rst");
    @(posedge i_clk); #1;

    // Directed corner loads
    reset_mid_req();
    do_load(32'h100, 3'd2, 32'hDEADBEEF, 0);
    do_load(32'h203, 3'd0, 32'h80112233, 0);
    do_load(32'h203, 3'd4, 32'h80112233, 1);
    do_load(32'h202, 3'd1, 32'h80017FFF, 0);
    do_load(32'h200, 3'd5, 32'h80017FFF, 2);
    do_load(32'h102, 3'd2, 32'h11111111, 0);
    do_load(32'h000, 3'd3, 32'h22222222, 0);
    do_load(32'h301, 3'd5, 32'h33333333, 0);
    do_load(32'h305, 3'd6, 32'h44444444, 0);
    do_load(32'h404, 3'd2, 32'hCAFEF00D, 5);
    do_load(32'h511, 3'd0, 32'h0000FF00, TO_CYC - 1);
    do_load(32'h600, 3'd2, 32'h5A5A5A5A, TO_CYC + 4);
    do_load(32'h700, 3'd2, 32'h0BADF00D, 0);

    // Random loads
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [2:0] f;
      a = $urandom;
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: f = 3'd0;
          1: f = 3'd1;
          2: f = 3'd2;
          3: f = 3'd4;
          default: f = 3'd5;
        endcase
        if (f == 3'd2) a = a - (a % 4);
        else if (f == 3'd1 || f == 3'd5) a = a - (a % 2);
      end
      do_load(a, f, $urandom, $urandom_range(0, 6));
    end

    repeat (6) begin @(posedge i_clk); #1; end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
